id_unidad_riesgos_secuencial: RTL and testbench

Sequential, parametrised hazard unit for the ID stage of the 5-stage MIPS pipeline. Generalises load-use detection to a configurable memory latency, adds a stall-until-done handshake for multi-cycle EX operations (mult/div), and drives IF/ID and ID/EX flush/hold controls. It sits between the control unit, the pipeline latches and the PC register.

---
 rtl/id_unidad_riesgos_secuencial.sv | 157 +++++++++++++++
 tb/tb_id_unidad_riesgos_secuencial.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/id_unidad_riesgos_secuencial.sv
// ID-stage hazard unit: multi-cycle load-use stall, mult/div stall-until-done and flush control.
// Optional statistics counters are built only when RIESGOS_STATS_EN is defined.
module id_unidad_riesgos_secuencial #(
    parameter int unsigned RNBITS   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNTBITS  = 3,
    parameter int unsigned STATBITS = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_ID_EX_MemRead,
    input  logic [RNBITS-1:0]   i_ID_EX_Rt,
    input  logic [RNBITS-1:0]   i_IF_ID_Rs,
    input  logic [RNBITS-1:0]   i_IF_ID_Rt,
    input  logic                i_IF_ID_UsaRt,
    input  logic                i_ID_Unidad_Control_Jump,
    input  logic                i_EX_MEM_Flush,
    input  logic                i_EX_MC_Start,
    input  logic                i_EX_MC_Done,
    output logic                o_Mux_Riesgo,
    output logic                o_PC_Write,
    output logic                o_IF_ID_Write,
    output logic                o_ID_EX_Write,
    output logic                o_Latch_Flush,
    output logic                o_IF_ID_Flush,
    output logic                o_MC_Cancel,
    output logic [STATBITS-1:0] o_Stall_Cycles,
    output logic [STATBITS-1:0] o_Flush_Count
);

    typedef enum logic [1:0] {StIdle, StLoadStall, StMcBusy} state_e;

    state_e               state_q, state_d;
    logic [CNTBITS-1:0]   cnt_q, cnt_d;
    logic                 hazard;
    logic                 load_stall;
    logic                 mc_stall;
    logic                 cancel;

    always_comb begin
        hazard = i_ID_EX_MemRead && (i_ID_EX_Rt != '0) &&
                 ((i_ID_EX_Rt == i_IF_ID_Rs) ||
                  (i_IF_ID_UsaRt && (i_ID_EX_Rt == i_IF_ID_Rt)));
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_stall = 1'b0;
        mc_stall   = 1'b0;
        cancel     = 1'b0;
        if (i_EX_MEM_Flush) begin
            state_d = StIdle;
            cnt_d   = '0;
            cancel  = (state_q == StMcBusy) || i_EX_MC_Start;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_EX_MC_Start) begin
                        mc_stall = 1'b1;
                        state_d  = StMcBusy;
                    end else if (hazard) begin
                        load_stall = 1'b1;
                        // The detection cycle is the first stall cycle; only longer latencies need the FSM.
                        if (LOAD_LAT > 1) begin
                            state_d = StLoadStall;
                            cnt_d   = CNTBITS'(LOAD_LAT - 1);
                        end
                    end
                end
                StLoadStall: begin
                    load_stall = 1'b1;
                    if (cnt_q <= CNTBITS'(1)) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNTBITS'(1);
                    end
                end
                StMcBusy: begin
                    if (i_EX_MC_Done) begin
                        state_d = StIdle;
                    end else begin
                        mc_stall = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced to their idle values while reset is held, whatever the inputs do.
    always_comb begin
        o_Mux_Riesgo  = 1'b0;
        o_PC_Write    = 1'b1;
        o_IF_ID_Write = 1'b1;
        o_ID_EX_Write = 1'b1;
        o_Latch_Flush = 1'b0;
        o_IF_ID_Flush = 1'b0;
        o_MC_Cancel   = 1'b0;
        if (i_reset) begin
            if (i_EX_MEM_Flush) begin
                o_Latch_Flush = 1'b1;
                o_IF_ID_Flush = 1'b1;
                o_MC_Cancel   = cancel;
            end else if (load_stall) begin
                o_Mux_Riesgo  = 1'b1;
                o_PC_Write    = 1'b0;
                o_IF_ID_Write = 1'b0;
            end else if (mc_stall) begin
                o_PC_Write    = 1'b0;
                o_IF_ID_Write = 1'b0;
                o_ID_EX_Write = 1'b0;
            end else begin
                o_IF_ID_Flush = i_ID_Unidad_Control_Jump;
            end
        end
    end

`ifdef RIESGOS_STATS_EN
    logic [STATBITS-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!o_PC_Write && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + STATBITS'(1);
            end
            if (o_Latch_Flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + STATBITS'(1);
            end
        end
    end

    assign o_Stall_Cycles = stall_cnt_q;
    assign o_Flush_Count  = flush_cnt_q;
`else
    assign o_Stall_Cycles = '0;
    assign o_Flush_Count  = '0;
`endif

endmodule

// File: tb/tb_id_unidad_riesgos_secuencial.sv
// Bench for id_unidad_riesgos_secuencial: two instances (LOAD_LAT 3 and 1) against a
// remaining-cycles reference model, directed scenarios followed by random traffic.
module tb_id_unidad_riesgos_secuencial;

    localparam int unsigned RN = 5;
    localparam int unsigned SB = 16;
`ifdef RIESGOS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          memread, usart, jump, flush, start, done;
    logic [RN-1:0] ex_rt, rs, id_rt;

    logic [1:0]    mux, pcw, ifidw, idexw, lflush, ififlush, cancel;
    logic [SB-1:0] stall_cnt [2];
    logic [SB-1:0] flush_cnt [2];

    int checks = 0;
    int errors = 0;

    int unsigned lat       [2] = '{3, 1};
    int          load_left [2] = '{0, 0};
    bit          mc_busy   [2] = '{0, 0};
    int          exp_stall [2] = '{0, 0};
    int          exp_flush [2] = '{0, 0};

    always #5 clk = ~clk;

    id_unidad_riesgos_secuencial #(
        .RNBITS(RN), .LOAD_LAT(3), .CNTBITS(3), .STATBITS(SB)
    ) u_lat3 (
        .i_clk(clk), .i_reset(rst), .i_ID_EX_MemRead(memread), .i_ID_EX_Rt(ex_rt),
        .i_IF_ID_Rs(rs), .i_IF_ID_Rt(id_rt), .i_IF_ID_UsaRt(usart),
        .i_ID_Unidad_Control_Jump(jump), .i_EX_MEM_Flush(flush), .i_EX_MC_Start(start),
        .i_EX_MC_Done(done), .o_Mux_Riesgo(mux[0]), .o_PC_Write(pcw[0]),
        .o_IF_ID_Write(ifidw[0]), .o_ID_EX_Write(idexw[0]), .o_Latch_Flush(lflush[0]),
        .o_IF_ID_Flush(ififlush[0]), .o_MC_Cancel(cancel[0]),
        .o_Stall_Cycles(stall_cnt[0]), .o_Flush_Count(flush_cnt[0])
    );

    id_unidad_riesgos_secuencial #(
        .RNBITS(RN), .LOAD_LAT(1), .CNTBITS(3), .STATBITS(SB)
    ) u_lat1 (
        .i_clk(clk), .i_reset(rst), .i_ID_EX_MemRead(memread), .i_ID_EX_Rt(ex_rt),
        .i_IF_ID_Rs(rs), .i_IF_ID_Rt(id_rt), .i_IF_ID_UsaRt(usart),
        .i_ID_Unidad_Control_Jump(jump), .i_EX_MEM_Flush(flush), .i_EX_MC_Start(start),
        .i_EX_MC_Done(done), .o_Mux_Riesgo(mux[1]), .o_PC_Write(pcw[1]),
        .o_IF_ID_Write(ifidw[1]), .o_ID_EX_Write(idexw[1]), .o_Latch_Flush(lflush[1]),
        .o_IF_ID_Flush(ififlush[1]), .o_MC_Cancel(cancel[1]),
        .o_Stall_Cycles(stall_cnt[1]), .o_Flush_Count(flush_cnt[1])
    );

    task automatic chk(input string tag, input int idx, input logic [SB-1:0] got,
                       input logic [SB-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s[%0d] at %0t: got %0h expected %0h", tag, idx, $time, got, exp);
        end
    endtask

    // One clock cycle: outputs checked mid-cycle, model state advanced after the edge.
    task automatic cycle();
        logic [6:0] exp_v [2];
        int         nl    [2];
        bit         nb    [2];
        bit         h;
        @(negedge clk);
        h = memread && (ex_rt != 0) && ((ex_rt == rs) || (usart && (ex_rt == id_rt)));
        for (int i = 0; i < 2; i++) begin
            nl[i] = load_left[i];
            nb[i] = mc_busy[i];
            // vector order: mux, pc_w, if_id_w, id_ex_w, latch_flush, if_id_flush, cancel
            if (!rst) begin
                exp_v[i] = 7'b0111000;
                nl[i] = 0; nb[i] = 1'b0;
                exp_stall[i] = 0; exp_flush[i] = 0;
            end else if (flush) begin
                exp_v[i] = {6'b011111, mc_busy[i] || start};
                nl[i] = 0; nb[i] = 1'b0;
            end else if (mc_busy[i]) begin
                if (done) begin
                    exp_v[i] = {5'b01110, jump, 1'b0};
                    nb[i] = 1'b0;
                end else begin
                    exp_v[i] = 7'b0000000;
                end
            end else if (load_left[i] > 0) begin
                exp_v[i] = 7'b1001000;
                nl[i] = load_left[i] - 1;
            end else if (start) begin
                exp_v[i] = 7'b0000000;
                nb[i] = 1'b1;
            end else if (h) begin
                exp_v[i] = 7'b1001000;
                nl[i] = lat[i] - 1;
            end else begin
                exp_v[i] = {5'b01110, jump, 1'b0};
            end
            chk("ctl", i, SB'({mux[i], pcw[i], ifidw[i], idexw[i], lflush[i], ififlush[i],
                               cancel[i]}), SB'(exp_v[i]));
            chk("stall_cycles", i, stall_cnt[i], STATS ? SB'(exp_stall[i]) : '0);
            chk("flush_count", i, flush_cnt[i], STATS ? SB'(exp_flush[i]) : '0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            load_left[i] = nl[i];
            mc_busy[i]   = nb[i];
            if (rst && !exp_v[i][5] && exp_stall[i] < 65535) exp_stall[i]++;
            if (rst && exp_v[i][2] && exp_flush[i] < 65535) exp_flush[i]++;
        end
    endtask

    task automatic idle_inputs();
        memread = 0; usart = 0; jump = 0; flush = 0; start = 0; done = 0;
        ex_rt = '0; rs = '0; id_rt = '0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        // Reset state, including hazard-looking inputs that must be masked
        cycle();
        memread = 1; ex_rt = 5'd5; rs = 5'd5; start = 0;
        cycle();
        idle_inputs();
        rst = 1'b1;
        cycle();

        // Load-use on Rs
        memread = 1; ex_rt = 5'd5; rs = 5'd5;
        cycle();
        idle_inputs();
        repeat (4) cycle();

        // Register 0 never hazards; Rt ignored unless used
        memread = 1; ex_rt = 5'd0; rs = 5'd0;
        cycle();
        ex_rt = 5'd7; rs = 5'd3; id_rt = 5'd7; usart = 0;
        cycle();
        usart = 1;
        cycle();
        idle_inputs();
        repeat (3) cycle();

        // Multi-cycle op: Done in the Start cycle is ignored
        start = 1; done = 1;
        cycle();
        start = 0; done = 0;
        repeat (4) cycle();
        done = 1;
        cycle();
        done = 0;
        cycle();

        // Branch flush while multi-cycle op is busy
        start = 1;
        cycle();
        start = 0;
        cycle();
        flush = 1;
        cycle();
        flush = 0;
        repeat (2) cycle();

        // Jump held through a load stall
        memread = 1; ex_rt = 5'd4; rs = 5'd4; jump = 1;
        cycle();
        memread = 0;
        repeat (3) cycle();
        idle_inputs();

        // Reset asserted mid-stall
        memread = 1; ex_rt = 5'd6; rs = 5'd6;
        cycle();
        memread = 0;
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        idle_inputs();
        repeat (2) cycle();

        for (int n = 0; n < 2000; n++) begin
            rst     = ($urandom_range(63) != 0);
            memread = $urandom_range(1);
            ex_rt   = RN'($urandom_range(3));
            rs      = RN'($urandom_range(3));
            id_rt   = RN'($urandom_range(3));
            usart   = $urandom_range(1);
            jump    = ($urandom_range(3) == 0);
            flush   = ($urandom_range(15) == 0);
            start   = !memread && ($urandom_range(7) == 0);
            done    = ($urandom_range(3) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
